// File: rtl/exm_pkg.sv
// exm_pkg: shared opcode map, pipeline entry and flag types for the EX->MEM stage.
// Optional build macro consumed by ex_mem_stage: EXM_FLAG_RECOMPUTE_EN.
package exm_pkg;

    localparam int EXM_DATA_W = 32;
    localparam int EXM_RD_W   = 5;
    localparam int EXM_OP_W   = 5;

    localparam logic [EXM_OP_W-1:0] OP_ADD   = 5'b00010;
    localparam logic [EXM_OP_W-1:0] OP_ADDI  = 5'b00011;
    localparam logic [EXM_OP_W-1:0] OP_SUB   = 5'b00100;
    localparam logic [EXM_OP_W-1:0] OP_SUBI  = 5'b00101;
    localparam logic [EXM_OP_W-1:0] OP_MUL   = 5'b00110;
    localparam logic [EXM_OP_W-1:0] OP_DIV   = 5'b00111;
    localparam logic [EXM_OP_W-1:0] OP_AND   = 5'b01000;
    localparam logic [EXM_OP_W-1:0] OP_ANDI  = 5'b01001;
    localparam logic [EXM_OP_W-1:0] OP_OR    = 5'b01010;
    localparam logic [EXM_OP_W-1:0] OP_ORI   = 5'b01011;
    localparam logic [EXM_OP_W-1:0] OP_NOT   = 5'b01100;
    localparam logic [EXM_OP_W-1:0] OP_XOR   = 5'b01101;
    localparam logic [EXM_OP_W-1:0] OP_XORI  = 5'b01110;
    localparam logic [EXM_OP_W-1:0] OP_CMP   = 5'b01111;
    localparam logic [EXM_OP_W-1:0] OP_LD    = 5'b10000;
    localparam logic [EXM_OP_W-1:0] OP_ST    = 5'b10001;
    localparam logic [EXM_OP_W-1:0] OP_CALL  = 5'b10010;
    localparam logic [EXM_OP_W-1:0] OP_RET   = 5'b10011;
    localparam logic [EXM_OP_W-1:0] OP_RETI  = 5'b10100;
    localparam logic [EXM_OP_W-1:0] OP_MOVEH = 5'b11101;
    localparam logic [EXM_OP_W-1:0] OP_MOVEL = 5'b11110;

    typedef struct packed {
        logic [EXM_OP_W-1:0]   opcode;
        logic [EXM_RD_W-1:0]   rd;
        logic [EXM_DATA_W-1:0] result;
        logic [EXM_DATA_W-1:0] store_data;
        logic                  reg_we;
        logic                  rd_en;
        logic                  wr_en;
    } exm_entry_t;

    typedef struct packed {
        logic z;
        logic n;
    } flags_t;

    // Instructions that produce a register writeback; anything unlisted writes nothing.
    function automatic logic op_writes_reg(input logic [EXM_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV,
            OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI,
            OP_MOVEH, OP_MOVEL, OP_LD: op_writes_reg = 1'b1;
            default:                   op_writes_reg = 1'b0;
        endcase
    endfunction

    // Arith/logic group plus CMP update the architectural flags.
    function automatic logic op_sets_flags(input logic [EXM_OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV,
            OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR, OP_XORI,
            OP_CMP:  op_sets_flags = 1'b1;
            default: op_sets_flags = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exm_skid_buf.sv
// exm_skid_buf: generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready_o comes straight from a register (low only while the skid slot is full),
// so the upstream ready path carries no combinational dependence on out_ready_i.
module exm_skid_buf
    import exm_pkg::*;
#(
    parameter type T = exm_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    T     out_q, out_d;
    T     skid_q, skid_d;
    logic accept_w;
    logic out_free_w;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;
    assign accept_w    = in_valid_i & ~skid_valid_q;
    assign out_free_w  = ~out_valid_q | out_ready_i;

    // Slot movement: skid drains first to keep FIFO order; flush wins over everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free_w) begin
            if (skid_valid_q) begin
                // No accept can happen here: in_ready_o is low while the skid is full.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept_w;
                if (accept_w) begin
                    out_d = in_data_i;
                end
            end
        end else if (accept_w) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    // Slot registers; reset empties both entries and clears held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with opcode decode, {Z,N} flag register
// and a 2-entry skid buffer against MEM back-pressure.
// Build option EXM_FLAG_RECOMPUTE_EN: derive flags from ex_alu_out instead of ex_flags.
module ex_mem_stage
    import exm_pkg::*;
#(
    parameter int DATA_W = EXM_DATA_W,
    parameter int RD_W   = EXM_RD_W,
    parameter int OP_W   = EXM_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [1:0]        ex_flags,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              flush,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [OP_W-1:0]   mem_opcode,
    output logic [RD_W-1:0]   mem_rd,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              reg_we,
    output logic              flag_z,
    output logic              flag_n
);

    exm_entry_t in_entry_w;
    exm_entry_t out_entry_w;
    flags_t     flags_q, flags_d;
    flags_t     flags_in_w;
    logic       accept_w;

    // Decode travels with the entry so strobes stay aligned with data under stalls.
    always_comb begin
        in_entry_w            = '0;
        in_entry_w.opcode     = ex_opcode;
        in_entry_w.rd         = ex_rd;
        in_entry_w.result     = ex_alu_out;
        in_entry_w.store_data = ex_store_data;
        in_entry_w.reg_we     = op_writes_reg(ex_opcode);
        in_entry_w.rd_en      = (ex_opcode == OP_LD);
        in_entry_w.wr_en      = (ex_opcode == OP_ST);
    end

    exm_skid_buf #(
        .T (exm_entry_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (ex_valid),
        .in_ready_o  (ex_ready),
        .in_data_i   (in_entry_w),
        .out_valid_o (mem_valid),
        .out_ready_i (mem_ready),
        .out_data_o  (out_entry_w)
    );

    assign accept_w = ex_valid & ex_ready;

    // Flag source selection; handshake is identical in both builds.
`ifdef EXM_FLAG_RECOMPUTE_EN
    always_comb begin
        flags_in_w   = '0;
        flags_in_w.z = (ex_alu_out == '0);
        flags_in_w.n = ex_alu_out[DATA_W-1];
    end
`else
    always_comb begin
        flags_in_w   = '0;
        flags_in_w.z = ex_flags[1];
        flags_in_w.n = ex_flags[0];
    end
`endif

    // Flags update at accept time, so MEM stalls never delay them; a flushed accept never lands.
    always_comb begin
        flags_d = flags_q;
        if (accept_w && !flush && op_sets_flags(ex_opcode)) begin
            flags_d = flags_in_w;
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign mem_opcode     = out_entry_w.opcode;
    assign mem_rd         = out_entry_w.rd;
    assign mem_result     = out_entry_w.result;
    assign mem_store_data = out_entry_w.store_data;
    assign reg_we         = mem_valid & out_entry_w.reg_we;
    assign mem_rd_en      = mem_valid & out_entry_w.rd_en;
    assign mem_wr_en      = mem_valid & out_entry_w.wr_en;
    assign flag_z         = flags_q.z;
    assign flag_n         = flags_q.n;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus with a queue scoreboard for ex_mem_stage.
module tb_ex_mem_stage;
    import exm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_out;
    logic [1:0]  ex_flags;
    logic [31:0] ex_store_data;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_opcode;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        reg_we;
    logic        flag_z;
    logic        flag_n;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_opcode      (ex_opcode),
        .ex_rd          (ex_rd),
        .ex_alu_out     (ex_alu_out),
        .ex_flags       (ex_flags),
        .ex_store_data  (ex_store_data),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_opcode     (mem_opcode),
        .mem_rd         (mem_rd),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .reg_we         (reg_we),
        .flag_z         (flag_z),
        .flag_n         (flag_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sd;
        logic        we;
        logic        rde;
        logic        wre;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   c0, c1;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode, written out from the instruction list.
    function automatic exp_t model(input logic [4:0] op, input logic [4:0] rd,
                                   input logic [31:0] res, input logic [31:0] sd);
        exp_t e;
        e.op  = op;
        e.rd  = rd;
        e.res = res;
        e.sd  = sd;
        e.we  = (op == OP_ADD)  || (op == OP_ADDI) || (op == OP_SUB)  || (op == OP_SUBI) ||
                (op == OP_MUL)  || (op == OP_DIV)  || (op == OP_AND)  || (op == OP_ANDI) ||
                (op == OP_OR)   || (op == OP_ORI)  || (op == OP_NOT)  || (op == OP_XOR)  ||
                (op == OP_XORI) || (op == OP_MOVEH) || (op == OP_MOVEL) || (op == OP_LD);
        e.rde = (op == OP_LD);
        e.wre = (op == OP_ST);
        return e;
    endfunction

    // Monitor: every valid cycle must match the queue head; pop on handoff to MEM.
    always @(negedge clk) begin
        if (rst_n && mem_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got opcode 0x%0h result 0x%0h expected no entry", mem_opcode, mem_result);
            end else begin
                mon_e = exp_q[0];
                chk("mon_opcode", {27'd0, mem_opcode}, {27'd0, mon_e.op});
                chk("mon_rd", {27'd0, mem_rd}, {27'd0, mon_e.rd});
                chk("mon_result", mem_result, mon_e.res);
                chk("mon_store_data", mem_store_data, mon_e.sd);
                chk("mon_reg_we", {31'd0, reg_we}, {31'd0, mon_e.we});
                chk("mon_rd_en", {31'd0, mem_rd_en}, {31'd0, mon_e.rde});
                chk("mon_wr_en", {31'd0, mem_wr_en}, {31'd0, mon_e.wre});
                if (mem_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction, wait (bounded) for ready, push the expectation on accept.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] sd, input logic [1:0] fl);
        int n = 0;
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_rd         = rd;
        ex_alu_out    = res;
        ex_store_data = sd;
        ex_flags      = fl;
        while (!ex_ready && n < 20) begin
            step(1);
            n++;
        end
        if (!ex_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ex_ready stayed 0 for opcode 0x%0h, required 1", op);
            ex_valid = 1'b0;
            return;
        end
        step(1);
        exp_q.push_back(model(op, rd, res, sd));
        ex_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_rd = '0; ex_alu_out = '0;
        ex_flags = '0; ex_store_data = '0; flush = 1'b0; mem_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Reset state
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
        chk("rst_flag_n", {31'd0, flag_n}, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);

        // Streaming, one-cycle latency, back-to-back accepts
        mem_ready = 1'b1;
        send(OP_ADD, 5'd3, 32'h10, 32'h0, 2'b00);
        chk("lat_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("lat_mem_result", mem_result, 32'h10);
        chk("lat_reg_we", {31'd0, reg_we}, 32'd1);
        c0 = cyc;
        send(OP_ADDI, 5'd4, 32'h20, 32'h0, 2'b00);
        send(OP_XOR, 5'd5, 32'hAB, 32'h0, 2'b00);
        send(5'b00000, 5'd6, 32'h33, 32'h0, 2'b00);
        send(OP_CALL, 5'd7, 32'h44, 32'h0, 2'b00);
        send(OP_MOVEL, 5'd8, 32'h55, 32'h0, 2'b00);
        c1 = cyc;
        chk("b2b_cycles", c1 - c0, 32'd5);
        step(2);

        // Flags: CMP sets, ST holds, SUB clears
        send(OP_CMP, 5'd0, 32'h0, 32'h0, 2'b10);
        chk("cmp_flag_z", {31'd0, flag_z}, 32'd1);
        chk("cmp_flag_n", {31'd0, flag_n}, 32'd0);
        chk("cmp_reg_we", {31'd0, reg_we}, 32'd0);
        send(OP_ST, 5'd0, 32'h104, 32'h55, 2'b11);
        chk("st_hold_z", {31'd0, flag_z}, 32'd1);
        chk("st_hold_n", {31'd0, flag_n}, 32'd0);
        send(OP_SUB, 5'd2, 32'h5, 32'h0, 2'b00);
        chk("sub_flag_z", {31'd0, flag_z}, 32'd0);
        step(2);

        // Stall: LD then ST fill both slots, third instruction is refused
        mem_ready = 1'b0;
        send(OP_LD, 5'd7, 32'h100, 32'h0, 2'b00);
        chk("stall_ready_1", {31'd0, ex_ready}, 32'd1);
        send(OP_ST, 5'd0, 32'h104, 32'hDEAD, 2'b00);
        chk("stall_ready_2", {31'd0, ex_ready}, 32'd0);
        ex_valid = 1'b1; ex_opcode = OP_ADD; ex_rd = 5'd9; ex_alu_out = 32'h999; ex_flags = 2'b00;
        step(3);
        chk("stall_no_accept", {31'd0, ex_ready}, 32'd0);
        chk("stall_stable", mem_result, 32'h100);
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("drain_ld_rd_en", {31'd0, mem_rd_en}, 32'd1);
        step(1);
        chk("drain_st_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("drain_st_result", mem_result, 32'h104);
        chk("drain_ready", {31'd0, ex_ready}, 32'd1);
        step(1);
        chk("drain_empty", {31'd0, mem_valid}, 32'd0);

        // Flush with skid full and a CMP presented
        mem_ready = 1'b0;
        send(OP_LD, 5'd1, 32'h200, 32'h0, 2'b00);
        send(OP_ST, 5'd0, 32'h204, 32'h77, 2'b00);
        ex_valid = 1'b1; ex_opcode = OP_CMP; ex_rd = 5'd0; ex_alu_out = 32'h0; ex_flags = 2'b10;
        flush = 1'b1;
        step(1);
        flush = 1'b0; ex_valid = 1'b0;
        exp_q.delete();
        chk("flush_full_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_full_ready", {31'd0, ex_ready}, 32'd1);
        chk("flush_full_z", {31'd0, flag_z}, 32'd0);

        // Flush cancels a real accept and its flag update
        send(OP_LD, 5'd1, 32'h300, 32'h0, 2'b00);
        ex_valid = 1'b1; ex_opcode = OP_CMP; ex_rd = 5'd0; ex_alu_out = 32'h0; ex_flags = 2'b10;
        flush = 1'b1;
        step(1);
        flush = 1'b0; ex_valid = 1'b0;
        exp_q.delete();
        chk("flush_acc_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_acc_z", {31'd0, flag_z}, 32'd0);
        chk("flush_acc_ready", {31'd0, ex_ready}, 32'd1);
        step(2);
        chk("flush_acc_gone", {31'd0, mem_valid}, 32'd0);

        // Reset mid-stream with both slots full and Z set
        mem_ready = 1'b0;
        send(OP_CMP, 5'd0, 32'h0, 32'h0, 2'b10);
        send(OP_LD, 5'd2, 32'h400, 32'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("midrst_flag_z", {31'd0, flag_z}, 32'd0);
        chk("midrst_flag_n", {31'd0, flag_n}, 32'd0);
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        step(1);

        // Flag source option: negative result with ex_flags=00
        mem_ready = 1'b1;
        send(OP_SUB, 5'd9, 32'h8000_0000, 32'h0, 2'b00);
`ifdef EXM_FLAG_RECOMPUTE_EN
        chk("opt_flag_n", {31'd0, flag_n}, 32'd1);
`else
        chk("opt_flag_n", {31'd0, flag_n}, 32'd0);
`endif
        chk("opt_flag_z", {31'd0, flag_z}, 32'd0);
        step(2);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
